// File: rtl/lcd_fill_rect.sv
// lcd_fill_rect
// Rectangle-fill engine for the ST7735 display path. A start pulse latches a
// rectangle and a colour. The engine then sends CASET/RASET with the window
// bounds and RAMWR, and streams width*height RGB565 pixels as hi/lo data bytes.
// Each byte is handed to the SPI writer with a one-cycle en_write pulse. The
// engine waits for wr_done before it moves to the next byte.
//
// Ports:
//   sys_clk   - system clock, rising edge
//   sys_rst   - synchronous active-high reset
//   start     - one-cycle request, honoured only while idle
//   x0, y0    - top-left corner (latched on accept)
//   width     - column count (latched on accept)
//   height    - row count (latched on accept)
//   color     - RGB565 fill colour (latched on accept)
//   wr_done   - writer has finished shifting the current byte
//   lcd_data  - {DC, byte}; DC=0 command, DC=1 data
//   en_write  - one-cycle pulse: transmit lcd_data
//   busy      - request in progress
//   done      - one-cycle completion pulse
module lcd_fill_rect #(
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [7:0]  x0,
  input  logic [7:0]  y0,
  input  logic [7:0]  width,
  input  logic [7:0]  height,
  input  logic [15:0] color,
  input  logic        wr_done,
  output logic [8:0]  lcd_data,
  output logic        en_write,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] XOFF    = 16'(X_OFFSET);
  localparam logic [15:0] YOFF    = 16'(Y_OFFSET);
  // Byte index 11 marks the pixel phase; 0..10 are the header bytes.
  localparam logic [3:0]  PIX_IDX = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [15:0] color_q, color_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic [8:0]  lcd_data_q, lcd_data_d;
  logic        en_write_q, en_write_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0]  idx_nxt;
  logic [8:0]  seq_byte;

  // Byte that follows the header byte currently on the bus. Index 11 is
  // the first pixel's high byte.
  always_comb begin
    idx_nxt  = idx_q + 4'd1;
    seq_byte = {1'b1, color_q[15:8]};
    case (idx_nxt)
      4'd1:    seq_byte = {1'b1, xs_q[15:8]};
      4'd2:    seq_byte = {1'b1, xs_q[7:0]};
      4'd3:    seq_byte = {1'b1, xe_q[15:8]};
      4'd4:    seq_byte = {1'b1, xe_q[7:0]};
      4'd5:    seq_byte = {1'b0, 8'h2B};
      4'd6:    seq_byte = {1'b1, ys_q[15:8]};
      4'd7:    seq_byte = {1'b1, ys_q[7:0]};
      4'd8:    seq_byte = {1'b1, ye_q[15:8]};
      4'd9:    seq_byte = {1'b1, ye_q[7:0]};
      4'd10:   seq_byte = {1'b0, 8'h2C};
      default: seq_byte = {1'b1, color_q[15:8]};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    color_d    = color_q;
    pix_cnt_d  = pix_cnt_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    lcd_data_d = lcd_data_q;
    busy_d     = busy_q;
    en_write_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xs_d      = {8'h00, x0} + XOFF;
          xe_d      = {8'h00, x0} + {8'h00, width} - 16'd1 + XOFF;
          ys_d      = {8'h00, y0} + YOFF;
          ye_d      = {8'h00, y0} + {8'h00, height} - 16'd1 + YOFF;
          color_d   = color;
          pix_cnt_d = {8'h00, width} * {8'h00, height};
          idx_d     = 4'd0;
          phase_d   = 1'b0;
          if (width == 8'd0 || height == 8'd0) begin
            // An empty rectangle sends no bytes. busy never rises.
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = S_ISSUE;
            en_write_d = 1'b1;
            busy_d     = 1'b1;
            lcd_data_d = {1'b0, 8'h2A};
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wr_done) begin
          if (idx_q != PIX_IDX) begin
            idx_d      = idx_nxt;
            lcd_data_d = seq_byte;
            state_d    = S_ISSUE;
            en_write_d = 1'b1;
          end else if (!phase_q) begin
            phase_d    = 1'b1;
            lcd_data_d = {1'b1, color_q[7:0]};
            state_d    = S_ISSUE;
            en_write_d = 1'b1;
          end else if (pix_cnt_q == 16'd1) begin
            // The low byte of the last pixel has been sent.
            pix_cnt_d = 16'd0;
            phase_d   = 1'b0;
            state_d   = S_FINISH;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end else begin
            pix_cnt_d  = pix_cnt_q - 16'd1;
            phase_d    = 1'b0;
            lcd_data_d = {1'b1, color_q[15:8]};
            state_d    = S_ISSUE;
            en_write_d = 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      xs_q       <= 16'd0;
      xe_q       <= 16'd0;
      ys_q       <= 16'd0;
      ye_q       <= 16'd0;
      color_q    <= 16'd0;
      pix_cnt_q  <= 16'd0;
      idx_q      <= 4'd0;
      phase_q    <= 1'b0;
      lcd_data_q <= 9'h000;
      en_write_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      color_q    <= color_d;
      pix_cnt_q  <= pix_cnt_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      lcd_data_q <= lcd_data_d;
      en_write_q <= en_write_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign lcd_data = lcd_data_q;
  assign en_write = en_write_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Directed testbench for lcd_fill_rect.
// Two instances are used. dut0 has zero offsets. dut1 has X_OFFSET=2 and
// Y_OFFSET=1. A writer model answers each en_write with a wr_done after a
// chosen latency. It records the byte stream and the done pulses of the
// selected instance.
module tb_lcd_fill_rect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst = 1'b1;
  logic        start_v   [2] = '{1'b0, 1'b0};
  logic        wr_done_v [2] = '{1'b0, 1'b0};
  logic [7:0]  x0 = 8'd0, y0 = 8'd0, width = 8'd0, height = 8'd0;
  logic [15:0] color = 16'd0;
  logic [8:0]  lcd_v  [2];
  logic        en_v   [2];
  logic        busy_v [2];
  logic        done_v [2];

  lcd_fill_rect #(.X_OFFSET(0), .Y_OFFSET(0)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[0]),
    .x0(x0), .y0(y0), .width(width), .height(height), .color(color),
    .wr_done(wr_done_v[0]), .lcd_data(lcd_v[0]), .en_write(en_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  lcd_fill_rect #(.X_OFFSET(2), .Y_OFFSET(1)) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[1]),
    .x0(x0), .y0(y0), .width(width), .height(height), .color(color),
    .wr_done(wr_done_v[1]), .lcd_data(lcd_v[1]), .en_write(en_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         sel      = 0;
  int         lat      = 3;
  int         wcnt [2] = '{0, 0};
  int         done_cnt = 0;
  logic [8:0] cap_q [$];

  // Writer model and observer. It works on the falling edge, away from the
  // DUT's active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      wr_done_v[i] = 1'b0;
      if (sys_rst) begin
        wcnt[i] = 0;
      end else begin
        if (wcnt[i] > 0) begin
          wcnt[i] = wcnt[i] - 1;
          if (wcnt[i] == 0) wr_done_v[i] = 1'b1;
        end
        if (en_v[i]) wcnt[i] = lat;
      end
    end
    if (en_v[sel]) cap_q.push_back(lcd_v[sel]);
    if (done_v[sel]) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // start is driven for one cycle. The task returns in the first ISSUE cycle.
  task automatic pulse_start(input int which, input logic [7:0] ax, input logic [7:0] ay,
                             input logic [7:0] aw, input logic [7:0] ah, input logic [15:0] ac);
    x0 = ax; y0 = ay; width = aw; height = ah; color = ac;
    start_v[which] = 1'b1;
    tick();
    start_v[which] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_v[sel] !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done"}, 32'(done_v[sel]), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_v[sel]), 32'd0);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(cap_q.size() >= n), 32'd1);
  endtask

  // Compares every byte from index 11 on with the colour's hi/lo pattern.
  task automatic check_pixels(input string tag, input logic [15:0] c);
    int bad = 0;
    for (int i = 11; i < cap_q.size(); i++) begin
      if (cap_q[i] !== ((i % 2 == 1) ? {1'b1, c[15:8]} : {1'b1, c[7:0]})) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  logic [8:0] basic_exp [15] = '{
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h101,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h100,
    9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100
  };
  logic [8:0] off_exp [11] = '{
    9'h02A, 9'h100, 9'h10C, 9'h100, 9'h110,
    9'h02B, 9'h100, 9'h115, 9'h100, 9'h118, 9'h02C
  };

  initial begin
    int cmd_cnt;
    // Reset
    repeat (3) tick();
    check("rst_lcd_data", 32'(lcd_v[0]), 32'h000);
    check("rst_en_write", 32'(en_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    sys_rst = 1'b0;
    tick();

    // Basic fill 2x1 red at the origin
    sel = 0; lat = 3; cap_q.delete(); done_cnt = 0;
    pulse_start(0, 8'd0, 8'd0, 8'd2, 8'd1, 16'hF800);
    check("basic_first_en", 32'(en_v[0]), 32'd1);
    check("basic_first_byte", 32'(lcd_v[0]), 32'h02A);
    check("basic_busy", 32'(busy_v[0]), 32'd1);
    tick();
    check("basic_en_one_cycle", 32'(en_v[0]), 32'd0);
    check("basic_data_held", 32'(lcd_v[0]), 32'h02A);
    wait_done("basic", 500);
    tick();
    check("basic_count", 32'(cap_q.size()), 32'd15);
    for (int i = 0; i < 15 && i < cap_q.size(); i++)
      check($sformatf("basic_byte%0d", i), 32'(cap_q[i]), 32'(basic_exp[i]));
    check("basic_done_cnt", 32'(done_cnt), 32'd1);
    check("basic_done_pulse", 32'(done_v[0]), 32'd0);
    $display("fill basic: %0d bytes, %0d done", cap_q.size(), done_cnt);

    // Offsets: dut1 with X_OFFSET=2, Y_OFFSET=1
    sel = 1; cap_q.delete(); done_cnt = 0;
    pulse_start(1, 8'd10, 8'd20, 8'd5, 8'd4, 16'h07E0);
    wait_done("offset", 2000);
    tick();
    check("offset_count", 32'(cap_q.size()), 32'd51);
    for (int i = 0; i < 11 && i < cap_q.size(); i++)
      check($sformatf("offset_byte%0d", i), 32'(cap_q[i]), 32'(off_exp[i]));
    check_pixels("offset_pixels", 16'h07E0);
    $display("fill offset: %0d bytes, %0d done", cap_q.size(), done_cnt);

    // Zero size
    sel = 0; cap_q.delete(); done_cnt = 0;
    pulse_start(0, 8'd5, 8'd5, 8'd0, 8'd7, 16'hFFFF);
    check("zero_done_cycle1", 32'(done_v[0]), 32'd1);
    check("zero_busy", 32'(busy_v[0]), 32'd0);
    repeat (5) tick();
    check("zero_no_bytes", 32'(cap_q.size()), 32'd0);
    check("zero_done_cnt", 32'(done_cnt), 32'd1);
    check("zero_busy_after", 32'(busy_v[0]), 32'd0);
    $display("fill zero: %0d bytes, %0d done", cap_q.size(), done_cnt);

    // start while busy is ignored
    cap_q.delete(); done_cnt = 0;
    pulse_start(0, 8'd1, 8'd2, 8'd3, 8'd2, 16'h1234);
    wait_bytes("busy_reach_pixels", 13, 500);
    pulse_start(0, 8'd50, 8'd60, 8'd9, 8'd9, 16'hABCD);
    wait_done("busy", 1000);
    repeat (20) tick();
    check("busy_count", 32'(cap_q.size()), 32'd23);
    if (cap_q.size() >= 11) begin
      check("busy_xe_lo", 32'(cap_q[4]), 32'h103);
      check("busy_ys_lo", 32'(cap_q[7]), 32'h102);
      check("busy_ye_lo", 32'(cap_q[9]), 32'h103);
    end
    check_pixels("busy_pixels", 16'h1234);
    check("busy_done_cnt", 32'(done_cnt), 32'd1);
    $display("fill busy-reject: %0d bytes, %0d done", cap_q.size(), done_cnt);

    // Reset during the RASET bytes
    cap_q.delete(); done_cnt = 0;
    pulse_start(0, 8'd0, 8'd0, 8'd4, 8'd4, 16'h5555);
    wait_bytes("rst_reach_byte6", 7, 500);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    check("midrst_lcd_data", 32'(lcd_v[0]), 32'h000);
    check("midrst_en_write", 32'(en_v[0]), 32'd0);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_done", 32'(done_v[0]), 32'd0);
    repeat (20) tick();
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_bytes_stop", 32'(cap_q.size()), 32'd7);
    cap_q.delete();
    pulse_start(0, 8'd3, 8'd4, 8'd1, 8'd1, 16'hBEEF);
    wait_done("post_rst", 500);
    tick();
    check("post_rst_count", 32'(cap_q.size()), 32'd13);
    if (cap_q.size() >= 13) begin
      check("post_rst_xe_lo", 32'(cap_q[4]), 32'h103);
      check("post_rst_ye_lo", 32'(cap_q[9]), 32'h104);
      check("post_rst_pix_hi", 32'(cap_q[11]), 32'h1BE);
      check("post_rst_pix_lo", 32'(cap_q[12]), 32'h1EF);
    end
    check("post_rst_done_cnt", 32'(done_cnt), 32'd1);
    $display("fill reset-recover: %0d bytes, %0d done", cap_q.size(), done_cnt);

    // Full screen 128x160 with the fastest legal writer
    lat = 1; cap_q.delete(); done_cnt = 0;
    pulse_start(0, 8'd0, 8'd0, 8'd128, 8'd160, 16'h001F);
    wait_done("full", 90000);
    tick();
    check("full_count", 32'(cap_q.size()), 32'd40971);
    cmd_cnt = 0;
    foreach (cap_q[i]) if (cap_q[i][8] == 1'b0) cmd_cnt++;
    check("full_cmd_cnt", 32'(cmd_cnt), 32'd3);
    if (cap_q.size() >= 11) begin
      check("full_cmd_pos1", 32'(cap_q[0]), 32'h02A);
      check("full_cmd_pos6", 32'(cap_q[5]), 32'h02B);
      check("full_cmd_pos11", 32'(cap_q[10]), 32'h02C);
      check("full_xe_lo", 32'(cap_q[4]), 32'h17F);
      check("full_ye_lo", 32'(cap_q[9]), 32'h19F);
      check("full_last", 32'(cap_q[cap_q.size() - 1]), 32'h11F);
    end
    check("full_done_cnt", 32'(done_cnt), 32'd1);
    $display("fill full-screen: %0d bytes, %0d done", cap_q.size(), done_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
